// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port between two valid/ready requesters.
// A tag pipeline follows each access through the RAM read latency and routes the response home.
module ram_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned RAM_SIZE   = 32'h20,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                    clka,
  input  logic                    rsta_n,
  input  logic                    req_valid_m0,
  output logic                    req_ready_m0,
  input  logic [DATA_WIDTH/8-1:0] req_we_m0,
  input  logic [ADDR_WIDTH-1:0]   req_addr_m0,
  input  logic [DATA_WIDTH-1:0]   req_wdata_m0,
  input  logic                    req_valid_m1,
  output logic                    req_ready_m1,
  input  logic [DATA_WIDTH/8-1:0] req_we_m1,
  input  logic [ADDR_WIDTH-1:0]   req_addr_m1,
  input  logic [DATA_WIDTH-1:0]   req_wdata_m1,
  output logic                    rsp_valid_m0,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_m0,
  output logic                    rsp_err_m0,
  output logic                    rsp_valid_m1,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_m1,
  output logic                    rsp_err_m1,
  output logic                    mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic [DATA_WIDTH-1:0]   mem_dout
);

  localparam int unsigned BW     = DATA_WIDTH / 8;
  localparam int unsigned Stages = RD_LATENCY + 1;

  typedef struct packed {
    logic vld;
    logic id;
    logic rd;
    logic err;
  } tag_t;

  logic                  ptr_q, ptr_d;
  logic                  grant0, grant1, accept, sel_id, in_range;
  logic [BW-1:0]         sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  tag_t                  tag_in, tag_out;
  tag_t [Stages-1:0]     tag_q;

  // ptr_q = 0 favours M0 on contention; ready is gated so it stays low in reset
  always_comb begin
    grant0    = rsta_n && req_valid_m0 && (!req_valid_m1 || !ptr_q);
    grant1    = rsta_n && req_valid_m1 && (!req_valid_m0 || ptr_q);
    accept    = grant0 || grant1;
    sel_id    = grant1;
    sel_we    = sel_id ? req_we_m1    : req_we_m0;
    sel_addr  = sel_id ? req_addr_m1  : req_addr_m0;
    sel_wdata = sel_id ? req_wdata_m1 : req_wdata_m0;
    in_range  = sel_addr < ADDR_WIDTH'(RAM_SIZE);
    ptr_d     = grant0 ? 1'b1 : (grant1 ? 1'b0 : ptr_q);
    tag_in    = '0;
    if (accept) begin
      tag_in.vld = 1'b1;
      tag_in.id  = sel_id;
      tag_in.rd  = (sel_we == '0);
      tag_in.err = !in_range;
    end
    tag_out = tag_q[RD_LATENCY];
  end

  assign req_ready_m0 = grant0;
  assign req_ready_m1 = grant1;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      ptr_q    <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      tag_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      mem_en   <= accept && in_range;
      mem_we   <= (accept && in_range) ? sel_we    : '0;
      mem_addr <= (accept && in_range) ? sel_addr  : '0;
      mem_din  <= (accept && in_range) ? sel_wdata : '0;
      tag_q[0] <= tag_in;
      for (int i = 1; i < int'(Stages); i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // The last tag stage lines up with mem_dout of the same access
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      rsp_valid_m0 <= 1'b0;
      rsp_rdata_m0 <= '0;
      rsp_err_m0   <= 1'b0;
      rsp_valid_m1 <= 1'b0;
      rsp_rdata_m1 <= '0;
      rsp_err_m1   <= 1'b0;
    end else begin
      rsp_valid_m0 <= tag_out.vld && !tag_out.id;
      rsp_err_m0   <= tag_out.vld && !tag_out.id && tag_out.err;
      rsp_rdata_m0 <= (tag_out.vld && !tag_out.id && tag_out.rd && !tag_out.err) ? mem_dout : '0;
      rsp_valid_m1 <= tag_out.vld && tag_out.id;
      rsp_err_m1   <= tag_out.vld && tag_out.id && tag_out.err;
      rsp_rdata_m1 <= (tag_out.vld && tag_out.id && tag_out.rd && !tag_out.err) ? mem_dout : '0;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed plus random traffic against a transaction-level model
// (ideal memory updated in acceptance order, responses due a fixed number of clocks later).
module tb_ram_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned RS = 32'h20;
  localparam int unsigned L  = 1;

  logic          clka = 1'b0;
  logic          rsta_n = 1'b0;
  logic          req_valid_m0 = 1'b0, req_valid_m1 = 1'b0;
  logic          req_ready_m0, req_ready_m1;
  logic [3:0]    req_we_m0 = '0, req_we_m1 = '0;
  logic [AW-1:0] req_addr_m0 = '0, req_addr_m1 = '0;
  logic [DW-1:0] req_wdata_m0 = '0, req_wdata_m1 = '0;
  logic          rsp_valid_m0, rsp_valid_m1, rsp_err_m0, rsp_err_m1;
  logic [DW-1:0] rsp_rdata_m0, rsp_rdata_m1;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  ram_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_SIZE(RS), .RD_LATENCY(L)
  ) dut (
    .clka(clka), .rsta_n(rsta_n),
    .req_valid_m0(req_valid_m0), .req_ready_m0(req_ready_m0), .req_we_m0(req_we_m0),
    .req_addr_m0(req_addr_m0), .req_wdata_m0(req_wdata_m0),
    .req_valid_m1(req_valid_m1), .req_ready_m1(req_ready_m1), .req_we_m1(req_we_m1),
    .req_addr_m1(req_addr_m1), .req_wdata_m1(req_wdata_m1),
    .rsp_valid_m0(rsp_valid_m0), .rsp_rdata_m0(rsp_rdata_m0), .rsp_err_m0(rsp_err_m0),
    .rsp_valid_m1(rsp_valid_m1), .rsp_rdata_m1(rsp_rdata_m1), .rsp_err_m1(rsp_err_m1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clka = ~clka;

  // Attached RAM: write-first, read data appears L clocks after the enable edge
  logic [DW-1:0] ram [0:RS-1];
  logic [DW-1:0] rd_pipe [0:L-1];
  assign mem_dout = rd_pipe[L-1];

  always @(posedge clka) begin
    logic [DW-1:0] w;
    if (mem_en && mem_addr < AW'(RS)) begin
      w = ram[mem_addr[4:0]];
      for (int b = 0; b < 4; b++) if (mem_we[b]) w[8*b +: 8] = mem_din[8*b +: 8];
      ram[mem_addr[4:0]] <= w;
      rd_pipe[0] <= w;
    end
    for (int i = 1; i < int'(L); i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Reference model
  typedef struct {
    int unsigned   due;
    logic          m;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [DW-1:0] ref_mem [0:RS-1];
  logic          ref_ptr;
  int unsigned   cyc;
  logic          exp_g0, exp_g1;
  logic          exp_en;
  logic [3:0]    exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_din;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    ref_ptr = 1'b0;
    exp_en = 1'b0; exp_we = '0; exp_addr = '0; exp_din = '0;
    exp_g0 = 1'b0; exp_g1 = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready_m0"}, 64'(req_ready_m0), 0);
    chk({tag, "_ready_m1"}, 64'(req_ready_m1), 0);
    chk({tag, "_rsp_m0"}, {rsp_valid_m0, rsp_err_m0, rsp_rdata_m0}, 0);
    chk({tag, "_rsp_m1"}, {rsp_valid_m1, rsp_err_m1, rsp_rdata_m1}, 0);
    chk({tag, "_mem"}, {mem_en, mem_we, mem_addr, mem_din[26:0]}, 0);
    chk({tag, "_mem_din"}, 64'(mem_din), 0);
  endtask

  // Called just after the falling edge with inputs settled
  task automatic check_cycle();
    logic          ev0, ev1, ee0, ee1;
    logic [DW-1:0] ed0, ed1;
    rsp_t          it;
    exp_g0 = req_valid_m0 && (!req_valid_m1 || ref_ptr == 1'b0);
    exp_g1 = req_valid_m1 && (!req_valid_m0 || ref_ptr == 1'b1);
    chk("req_ready_m0", 64'(req_ready_m0), 64'(exp_g0));
    chk("req_ready_m1", 64'(req_ready_m1), 64'(exp_g1));
    ev0 = 0; ev1 = 0; ee0 = 0; ee1 = 0; ed0 = '0; ed1 = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      it = exp_q.pop_front();
      if (it.m) begin ev1 = 1; ed1 = it.rdata; ee1 = it.err; end
      else      begin ev0 = 1; ed0 = it.rdata; ee0 = it.err; end
    end
    chk("rsp_valid_m0", 64'(rsp_valid_m0), 64'(ev0));
    chk("rsp_rdata_m0", 64'(rsp_rdata_m0), 64'(ed0));
    chk("rsp_err_m0", 64'(rsp_err_m0), 64'(ee0));
    chk("rsp_valid_m1", 64'(rsp_valid_m1), 64'(ev1));
    chk("rsp_rdata_m1", 64'(rsp_rdata_m1), 64'(ed1));
    chk("rsp_err_m1", 64'(rsp_err_m1), 64'(ee1));
    chk("mem_en", 64'(mem_en), 64'(exp_en));
    chk("mem_we", 64'(mem_we), 64'(exp_we));
    chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
    chk("mem_din", 64'(mem_din), 64'(exp_din));
  endtask

  // Called at the rising edge: apply the accepted command to the ideal memory
  task automatic model_edge();
    rsp_t          it;
    logic [3:0]    we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    cyc++;
    exp_en = 0; exp_we = '0; exp_addr = '0; exp_din = '0;
    if (exp_g0 || exp_g1) begin
      it.m = exp_g1;
      we = exp_g1 ? req_we_m1 : req_we_m0;
      a  = exp_g1 ? req_addr_m1 : req_addr_m0;
      d  = exp_g1 ? req_wdata_m1 : req_wdata_m0;
      it.due = cyc + L + 1;
      it.rdata = '0;
      it.err = (a >= AW'(RS));
      if (!it.err) begin
        exp_en = 1; exp_we = we; exp_addr = a; exp_din = d;
        if (we != 0) begin
          for (int b = 0; b < 4; b++) if (we[b]) ref_mem[a[4:0]][8*b +: 8] = d[8*b +: 8];
        end else begin
          it.rdata = ref_mem[a[4:0]];
        end
      end
      exp_q.push_back(it);
      ref_ptr = ~it.m;
    end
  endtask

  task automatic tick();
    #1 check_cycle();
    @(posedge clka);
    model_edge();
    @(negedge clka);
  endtask

  task automatic drive0(input logic v, input logic [3:0] we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    req_valid_m0 = v; req_we_m0 = we; req_addr_m0 = a; req_wdata_m0 = d;
  endtask

  task automatic drive1(input logic v, input logic [3:0] we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    req_valid_m1 = v; req_we_m1 = we; req_addr_m1 = a; req_wdata_m1 = d;
  endtask

  task automatic idle(input int n);
    drive0(0, 0, 0, 0); drive1(0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Entered just after a falling edge; asserts reset asynchronously mid-cycle
  task automatic do_reset();
    #2 rsta_n = 1'b0;
    #1 check_zero("rst_async");
    model_reset();
    @(negedge clka);
    #1 check_zero("rst_hold");
    @(negedge clka);
    rsta_n = 1'b1;
  endtask

  logic          p0v, p1v;
  logic [3:0]    p0we, p1we;
  logic [AW-1:0] p0a, p1a;
  logic [DW-1:0] p0d, p1d;

  initial begin
    for (int i = 0; i < int'(RS); i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    for (int i = 0; i < int'(L); i++) rd_pipe[i] = '0;
    cyc = 0;
    model_reset();

    // Reset with both requesters valid: ready must stay low
    drive0(1, 0, 1, 0); drive1(1, 0, 2, 0);
    @(negedge clka);
    #1 check_zero("reset");
    @(negedge clka);
    rsta_n = 1'b1;
    idle(1);

    // Single write then read
    drive0(1, 4'hf, 32'h0, 32'hcafecafe); tick();
    drive0(1, 4'h0, 32'h0, 32'h0); tick();
    idle(4);

    // Contention from a fresh reset: M0, M1, M0, M1
    do_reset();
    drive0(1, 0, 32'h1, 0); drive1(1, 0, 32'h2, 0);
    for (int i = 0; i < 4; i++) tick();
    idle(4);

    // Out of range write, then unaffected neighbour read
    drive1(1, 4'hf, 32'h24, 32'h12345678); tick();
    drive1(0, 0, 0, 0); drive0(1, 0, 32'h4, 0); tick();
    idle(4);

    // Byte enables
    drive0(1, 4'hf, 32'h10, 32'hffffffff); tick();
    drive0(1, 4'b0100, 32'h10, 32'h00aa0000); tick();
    drive0(1, 4'h0, 32'h10, 32'h0); tick();
    idle(4);
    chk("byte_enable_model", 64'(ref_mem[16]), 64'h00000000ffaaffff);

    // Streaming reads 0..7
    for (int i = 0; i < 8; i++) begin
      drive0(1, 0, AW'(i), 0); tick();
    end
    idle(4);

    // Address boundary
    drive1(1, 0, AW'(RS - 1), 0); tick();
    drive1(1, 0, AW'(RS), 0); tick();
    idle(4);

    // Random traffic, each command held until granted
    p0v = 0; p1v = 0;
    for (int n = 0; n < 300; n++) begin
      if (!p0v && $urandom_range(0, 99) < 65) begin
        p0v = 1; p0we = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
        p0a = AW'($urandom_range(0, RS + 7)); p0d = $urandom;
      end
      if (!p1v && $urandom_range(0, 99) < 65) begin
        p1v = 1; p1we = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
        p1a = AW'($urandom_range(0, RS + 7)); p1d = $urandom;
      end
      drive0(p0v, p0v ? p0we : 4'h0, p0v ? p0a : '0, p0v ? p0d : '0);
      drive1(p1v, p1v ? p1we : 4'h0, p1v ? p1a : '0, p1v ? p1d : '0);
      tick();
      if (exp_g0) p0v = 0;
      if (exp_g1) p1v = 0;
    end
    idle(4);

    // Reset one cycle after two reads are accepted
    drive0(1, 0, 32'h3, 0); drive1(1, 0, 32'h5, 0);
    tick(); tick();
    idle(1);
    do_reset();
    idle(5);
    drive0(1, 0, 32'h6, 0); drive1(1, 0, 32'h7, 0);
    #1 chk("first_grant_after_reset_m0", 64'(req_ready_m0), 64'h1);
    tick(); tick();
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one port (A side) of the ram_infra dual-port block RAM between two requesters, M0 and M1.
- Each requester has a valid/ready command channel and a response channel. The arbiter grants round-robin and issues at most one memory access per clock.
- It tracks in-flight accesses through the RAM read latency and routes each response back to its issuer.
- Accesses at addresses >= RAM_SIZE never reach the RAM and return an error response.

Parameters:
- DATA_WIDTH, 32, data bus width; must be a multiple of 8.
- ADDR_WIDTH, 32, address width.
- RAM_SIZE, 32'h20, number of valid addresses in the attached RAM.
- RD_LATENCY, 1, clocks from a mem_en cycle to valid mem_dout; legal range 1..4.

Ports:
- clka  in  1  clock; ram_infra is clocked from the same net.
- rsta_n  in  1  reset, asynchronous, active-low.
- req_valid_m0 / req_valid_m1  in  1  command valid.
- req_ready_m0 / req_ready_m1  out  1  command accepted this cycle.
- req_we_m0 / req_we_m1  in  DATA_WIDTH/8  byte write enables; all zero means read.
- req_addr_m0 / req_addr_m1  in  ADDR_WIDTH  address.
- req_wdata_m0 / req_wdata_m1  in  DATA_WIDTH  write data.
- rsp_valid_m0 / rsp_valid_m1  out  1  one-cycle response pulse.
- rsp_rdata_m0 / rsp_rdata_m1  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err_m0 / rsp_err_m1  out  1  out-of-range access.
- mem_en  out  1  to ram_infra ena.
- mem_we  out  DATA_WIDTH/8  to ram_infra wea.
- mem_addr  out  ADDR_WIDTH  to ram_infra addra.
- mem_din  out  DATA_WIDTH  to ram_infra dina.
- mem_dout  in  DATA_WIDTH  from ram_infra douta.

Behaviour:
- Reset: all outputs are 0 while rsta_n is low.
  - Round-robin pointer resets to M0.
  - In-flight pipeline is cleared; responses in flight are discarded, never emitted.
- Grant is combinational and taken within one cycle.
  - Only one requester valid: it gets ready.
  - Both valid: the pointer side gets ready.
  - After any grant, the pointer moves to the other master. If no grant, the pointer holds.
  - ready is never asserted without the matching valid. A requester holds its command stable until ready.
- Acceptance edge E: valid && ready sampled at the edge.
  - In-range access (addr < RAM_SIZE): mem_en=1, mem_we, mem_addr and mem_din are registered at E and held for exactly one cycle. In idle cycles they return to 0.
  - Out-of-range access: mem_en stays 0 and the RAM is untouched.
- Response timing: every accepted command produces exactly one response, in acceptance order.
  - rsp_valid is high for the single cycle after edge E+RD_LATENCY+1; with RD_LATENCY=1 it asserts after E+2.
  - Reads: rsp_rdata holds mem_dout, captured at edge E+RD_LATENCY+1.
  - Writes: rsp_rdata = 0, rsp_err = 0.
  - Out-of-range: rsp_err = 1, rsp_rdata = 0, with the same latency as in-range.
- Tag pipeline: RD_LATENCY+1 stages, each stage holding {valid, master id, is_read, err}.
  - It is fully pipelined; sustained throughput is 1 command per clock with no stalls.
  - Responses have no backpressure.
  - The unselected master's rsp_* outputs stay 0.
- Ordering:
  - Back-to-back write then read to the same address returns the new data, because the RAM is write-first and the port is shared.
  - A response and a new grant to the same master in the same cycle are allowed.
- Address boundary: addr = RAM_SIZE-1 is in range; addr = RAM_SIZE is an error.
- Reset asserted mid-burst: outputs clear immediately (asynchronous). After release, no stale rsp_valid may appear.

Test Plan:
- Single write then read:
  - Stimulus: M0 writes 0x00 ← 0xcafecafe (we=4'hf), then reads 0x00.
  - Required: mem_en pulses once per command. Read rsp_valid_m0 asserts after E+2 with rsp_rdata_m0=0xcafecafe and err=0.
- Contention:
  - Stimulus: M0 and M1 both hold valid for 4 cycles after reset.
  - Required: grant order M0, M1, M0, M1, one per clock. Responses arrive in the same order, each 2 cycles after its grant.
- Out of range:
  - Stimulus: M1 writes 0x24 ← 0x12345678 (RAM_SIZE=0x20).
  - Required: mem_en stays 0 and rsp_err_m1=1 after E+2. A later read of 0x04 returns its prior value, unaffected.
- Byte enables:
  - Stimulus: write 0x10 ← 0xffffffff, then write 0x00aa0000 with we=4'b0100, then read 0x10.
  - Required: read returns 0xffaaffff.
- Back-to-back streaming:
  - Stimulus: M0 reads addresses 0..7 every cycle with M1 idle.
  - Required: 8 consecutive rsp_valid_m0 cycles with data in address order and no bubbles.
- Reset mid-operation:
  - Stimulus: drop rsta_n one cycle after two reads are accepted.
  - Required: all outputs are 0 during reset and no rsp_valid appears after release. The first grant after release goes to M0.
